bsg_hash_bank_gather: RTL and testbench

Reverse path of the bank hash. Collects responses from banks_p banks, each tagged with its bank-local index. Rebuilds the original global address and merges all banks into one in-order-per-bank output stream. Sits between the bank array and the requester, opposite the address-to-bank hash.

---
 rtl/bsg_hash_bank_pkg.sv | 52 +++++
 rtl/bsg_hash_bank_gather_arb.sv | 38 +++
 rtl/bsg_hash_bank_gather.sv | 112 +++++++++++
 tb/tb_bsg_hash_bank_gather.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_hash_bank_pkg.sv
// Shared types and address split/join helpers for the bank hash and its
// reverse gather path. Helpers work on the widest supported address and
// are narrowed by the caller.
package bsg_hash_bank_pkg;

  // Widest address / bank id the helpers handle; instances are checked against these.
  localparam int hash_bank_max_width_lp    = 256;
  localparam int hash_bank_max_lg_banks_lp = 8;

  // Default configuration: 2 banks, 128-bit address, 32-bit payload.
  localparam int hash_bank_def_banks_lp    = 2;
  localparam int hash_bank_def_lg_banks_lp = $clog2(hash_bank_def_banks_lp);
  localparam int hash_bank_def_width_lp    = 128;
  localparam int hash_bank_def_data_w_lp   = 32;

  // Gathered response entry, laid out for the default configuration.
  typedef struct packed {
    logic [hash_bank_def_width_lp-1:0]    addr;
    logic [hash_bank_def_data_w_lp-1:0]   data;
    logic [hash_bank_def_lg_banks_lp-1:0] bank;
  } hash_bank_entry_s;

  // Global address = {index, bank}: bank id in the low lg_banks bits.
  function automatic logic [hash_bank_max_width_lp-1:0] hash_bank_join(
    input logic [hash_bank_max_width_lp-1:0]    index,
    input logic [hash_bank_max_lg_banks_lp-1:0] bank,
    input int                                   lg_banks
  );
    logic [hash_bank_max_width_lp-1:0] mask;
    mask = (hash_bank_max_width_lp'(1) << lg_banks) - hash_bank_max_width_lp'(1);
    return (index << lg_banks) | (hash_bank_max_width_lp'(bank) & mask);
  endfunction

  // Bank-local index: the address with the bank bits shifted out.
  function automatic logic [hash_bank_max_width_lp-1:0] hash_bank_split_index(
    input logic [hash_bank_max_width_lp-1:0] addr,
    input int                                lg_banks
  );
    return addr >> lg_banks;
  endfunction

  // Bank id: the low lg_banks bits of the address.
  function automatic logic [hash_bank_max_lg_banks_lp-1:0] hash_bank_split_bank(
    input logic [hash_bank_max_width_lp-1:0] addr,
    input int                                lg_banks
  );
    logic [hash_bank_max_width_lp-1:0] mask;
    mask = (hash_bank_max_width_lp'(1) << lg_banks) - hash_bank_max_width_lp'(1);
    return hash_bank_max_lg_banks_lp'(addr & mask);
  endfunction

endpackage

// File: rtl/bsg_hash_bank_gather_arb.sv
// Round-robin select across bank valids. The pointer moves past the winner
// only when the grant is actually taken, so a stalled winner keeps priority.
module bsg_hash_bank_gather_arb #(
  parameter int banks_p     = 2,
  parameter int lg_banks_lp = $clog2(banks_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [banks_p-1:0]     v_i,
  input  logic                   take_i,
  output logic                   grant_v_o,
  output logic [lg_banks_lp-1:0] grant_id_o
);

  logic [lg_banks_lp-1:0] rr_r;
  logic [lg_banks_lp-1:0] idx;

  // First requester at or after rr_r; scanning from the far end lets the nearest win.
  always_comb begin
    grant_v_o  = 1'b0;
    grant_id_o = rr_r;
    idx        = rr_r;
    for (int i = banks_p - 1; i >= 0; i--) begin
      idx = rr_r + lg_banks_lp'(i);  // power-of-two bank count wraps for free
      if (v_i[idx]) begin
        grant_v_o  = 1'b1;
        grant_id_o = idx;
      end
    end
  end

  // Pointer advances to the bank after the one just served.
  always_ff @(posedge clk_i) begin
    if (reset_i)     rr_r <= '0;
    else if (take_i) rr_r <= grant_id_o + lg_banks_lp'(1);
  end

endmodule

// File: rtl/bsg_hash_bank_gather.sv
// Gathers per-bank responses into one stream, rebuilding the global address
// as {index, bank}. A 2-entry FIFO decouples banks from the consumer.
// Optional BSG_HASH_BANK_GATHER_STATS_EN adds a saturating stall counter.
module bsg_hash_bank_gather
  import bsg_hash_bank_pkg::*;
#(
  parameter int banks_p        = 2,
  parameter int width_p        = 128,
  parameter int data_width_p   = 32,
  parameter int lg_banks_lp    = $clog2(banks_p),
  parameter int index_width_lp = width_p - lg_banks_lp
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [banks_p-1:0]                 v_i,
  input  logic [banks_p*index_width_lp-1:0]  index_i,
  input  logic [banks_p*data_width_p-1:0]    data_i,
  output logic [banks_p-1:0]                 ready_o,
  output logic                               v_o,
  output logic [width_p-1:0]                 addr_o,
  output logic [data_width_p-1:0]            data_o,
  output logic [lg_banks_lp-1:0]             bank_o,
  input  logic                               yumi_i
`ifdef BSG_HASH_BANK_GATHER_STATS_EN
  ,output logic [31:0]                       stall_cnt_o
`endif
);

  if (banks_p < 2 || (banks_p & (banks_p - 1)) != 0)
    $error("banks_p must be a power of two >= 2");
  if (width_p > hash_bank_max_width_lp || lg_banks_lp > hash_bank_max_lg_banks_lp
      || width_p <= lg_banks_lp)
    $error("width_p / banks_p out of supported range");

  // Same layout as hash_bank_entry_s, sized to this instance.
  typedef struct packed {
    logic [width_p-1:0]      addr;
    logic [data_width_p-1:0] data;
    logic [lg_banks_lp-1:0]  bank;
  } entry_s;

  logic                   grant_v;
  logic [lg_banks_lp-1:0] grant_id;
  logic                   space;
  logic                   xfer;
  logic [1:0]             count_r;
  logic                   wptr_r;
  logic                   rptr_r;
  entry_s                 mem_r [2];
  entry_s                 entry_n;
  entry_s                 head;

  bsg_hash_bank_gather_arb #(.banks_p(banks_p)) u_arb (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .take_i     (xfer),
    .grant_v_o  (grant_v),
    .grant_id_o (grant_id)
  );

  // A full buffer still has room when the head leaves this same cycle.
  assign space   = (count_r != 2'd2) | yumi_i;
  assign xfer    = grant_v & space & ~reset_i;
  assign ready_o = xfer ? (banks_p'(1) << grant_id) : '0;

  // Build the entry for the granted bank.
  always_comb begin
    entry_n.addr = width_p'(hash_bank_join(
                     hash_bank_max_width_lp'(index_i[grant_id*index_width_lp +: index_width_lp]),
                     hash_bank_max_lg_banks_lp'(grant_id), lg_banks_lp));
    entry_n.data = data_i[grant_id*data_width_p +: data_width_p];
    entry_n.bank = grant_id;
  end

  // FIFO control: pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= '0;
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
    end else begin
      if (xfer)   wptr_r <= ~wptr_r;
      if (yumi_i) rptr_r <= ~rptr_r;
      count_r <= count_r + {1'b0, xfer} - {1'b0, yumi_i};
    end
  end

  // FIFO storage; payload is not reset.
  always_ff @(posedge clk_i) begin
    if (xfer) mem_r[wptr_r] <= entry_n;
  end

  assign head   = mem_r[rptr_r];
  assign v_o    = (count_r != 2'd0);
  assign addr_o = head.addr;
  assign data_o = head.data;
  assign bank_o = head.bank;

`ifdef BSG_HASH_BANK_GATHER_STATS_EN
  // Count cycles where a bank is waiting but nothing is accepted.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      stall_cnt_o <= '0;
    else if ((|v_i) && !xfer && (stall_cnt_o != 32'hFFFF_FFFF))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_hash_bank_gather.sv
// Directed checks on a 2-bank instance, then a randomized scoreboard run
// on a 4-bank instance.
module tb_bsg_hash_bank_gather;

  localparam int W   = 16;
  localparam int DW  = 8;
  localparam int IW2 = W - 1;
  localparam int IW4 = W - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 2-bank instance
  logic [1:0]       v2 = '0;
  logic [2*IW2-1:0] idx2 = '0;
  logic [2*DW-1:0]  dat2 = '0;
  logic [1:0]       ready2;
  logic             vo2;
  logic [W-1:0]     addr2;
  logic [DW-1:0]    do2;
  logic             bank2;
  logic             yumi2 = 1'b0;
`ifdef BSG_HASH_BANK_GATHER_STATS_EN
  logic [31:0]      stall2;
  logic [31:0]      stall4;
`endif

  // 4-bank instance
  logic [3:0]       v4 = '0;
  logic [4*IW4-1:0] idx4 = '0;
  logic [4*DW-1:0]  dat4 = '0;
  logic [3:0]       ready4;
  logic             vo4;
  logic [W-1:0]     addr4;
  logic [DW-1:0]    do4;
  logic [1:0]       bank4;
  logic             yumi4 = 1'b0;

  bsg_hash_bank_gather #(.banks_p(2), .width_p(W), .data_width_p(DW)) dut2 (
    .clk_i(clk), .reset_i(rst), .v_i(v2), .index_i(idx2), .data_i(dat2),
    .ready_o(ready2), .v_o(vo2), .addr_o(addr2), .data_o(do2), .bank_o(bank2),
    .yumi_i(yumi2)
`ifdef BSG_HASH_BANK_GATHER_STATS_EN
    , .stall_cnt_o(stall2)
`endif
  );

  bsg_hash_bank_gather #(.banks_p(4), .width_p(W), .data_width_p(DW)) dut4 (
    .clk_i(clk), .reset_i(rst), .v_i(v4), .index_i(idx4), .data_i(dat4),
    .ready_o(ready4), .v_o(vo4), .addr_o(addr4), .data_o(do4), .bank_o(bank4),
    .yumi_i(yumi4)
`ifdef BSG_HASH_BANK_GATHER_STATS_EN
    , .stall_cnt_o(stall4)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard state for the random run
  logic [23:0]  sb [4][$];
  logic [23:0]  e;
  logic [3:0]   pend;
  logic [IW4-1:0] seq [4];
  logic         gen;
  int           errs, pushed, popped, left;

  initial begin
    // reset: outputs idle, nothing accepted even with requests present
    v2 = 2'b11;
    tick();
    #1;
    chk("rst_ready", ready2, 2'b00);
    chk("rst_vo", vo2, 1'b0);
    v2 = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    chk("idle_vo", vo2, 1'b0);

    // single bank-1 response: index 5 -> addr 11
    v2 = 2'b10;
    idx2[IW2 +: IW2] = IW2'(5);
    dat2[DW +: DW]   = 8'hAA;
    #1;
    chk("t1_ready", ready2, 2'b10);
    tick();
    v2 = 2'b00;
    chk("t1_vo", vo2, 1'b1);
    chk("t1_addr", addr2, 16'd11);
    chk("t1_bank", bank2, 1'b1);
    chk("t1_data", do2, 8'hAA);
    yumi2 = 1'b1;
    tick();
    yumi2 = 1'b0;
    chk("t1_drained", vo2, 1'b0);

    // both banks valid every cycle: grants alternate 0,1,0,1
    idx2[0 +: IW2]   = IW2'(3);
    dat2[0 +: DW]    = 8'h30;
    idx2[IW2 +: IW2] = IW2'(7);
    dat2[DW +: DW]   = 8'h71;
    v2 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      yumi2 = (i > 0);
      #1;
      chk("t2_ready", ready2, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("t2_vo", vo2, 1'b1);
      chk("t2_bank", bank2, (i % 2 == 0) ? 1'b0 : 1'b1);
      chk("t2_addr", addr2, (i % 2 == 0) ? 16'd6 : 16'd15);
    end
    v2 = 2'b00;
    yumi2 = 1'b1;
    tick();
    yumi2 = 1'b0;
    chk("t2_drained", vo2, 1'b0);

    // backpressure: two accepted, then ready drops; a yumi frees a slot same cycle
    v2 = 2'b01;
    idx2[0 +: IW2] = IW2'(1); dat2[0 +: DW] = 8'h11;
    #1;
    chk("t3_ready_a", ready2, 2'b01);
    tick();
    idx2[0 +: IW2] = IW2'(2); dat2[0 +: DW] = 8'h12;
    #1;
    chk("t3_ready_b", ready2, 2'b01);
    tick();
    idx2[0 +: IW2] = IW2'(3); dat2[0 +: DW] = 8'h13;
    #1;
    chk("t3_ready_full", ready2, 2'b00);
    tick();
    chk("t3_head_addr", addr2, 16'd2);
    chk("t3_head_data", do2, 8'h11);
    yumi2 = 1'b1;
    #1;
    chk("t3_ready_yumi", ready2, 2'b01);
    tick();
    yumi2 = 1'b0;
    v2 = 2'b00;
    chk("t3_vo2", vo2, 1'b1);
    chk("t3_head2_addr", addr2, 16'd4);
    chk("t3_head2_data", do2, 8'h12);

    // reset with a full buffer: entries gone, pointer back to bank 0
    rst = 1'b1;
    v2 = 2'b01;
    #1;
    chk("t4_ready_in_rst", ready2, 2'b00);
    tick();
    chk("t4_vo_after_rst", vo2, 1'b0);
    rst = 1'b0;
    v2 = 2'b00;
    tick();
    chk("t4_vo_stays_empty", vo2, 1'b0);
    v2 = 2'b11;
    #1;
    chk("t4_rr_zero", ready2, 2'b01);
    v2 = 2'b00;

`ifdef BSG_HASH_BANK_GATHER_STATS_EN
    chk("st_reset", stall2, 32'd0);
    v2 = 2'b01;
    idx2[0 +: IW2] = IW2'(9);
    tick();
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("st_count7", stall2, 32'd7);
    v2 = 2'b00;
    yumi2 = 1'b1;
    tick();
    tick();
    yumi2 = 1'b0;
    chk("st_drained", vo2, 1'b0);
`endif

    // randomized 4-bank run with per-bank scoreboard
    pend = '0;
    errs = 0; pushed = 0; popped = 0;
    for (int b = 0; b < 4; b++) seq[b] = '0;
    for (int cyc = 0; cyc < 3060; cyc++) begin
      gen = (cyc < 3000);
      for (int b = 0; b < 4; b++) begin
        if (!pend[b] && gen && ($urandom_range(0, 1) == 1)) begin
          pend[b] = 1'b1;
          idx4[b*IW4 +: IW4] = seq[b];
          seq[b] = seq[b] + 1'b1;
          dat4[b*DW +: DW] = DW'($urandom_range(0, 255));
        end
      end
      v4 = pend;
      yumi4 = vo4 && (gen ? ($urandom_range(0, 3) != 0) : 1'b1);
      #1;
      if (yumi4) begin
        if (sb[bank4].size() == 0) errs++;
        else begin
          e = sb[bank4].pop_front();
          if ({addr4, do4} !== e) errs++;
          popped++;
        end
      end
      if ((ready4 & ~v4) != 4'b0 || (ready4 & (ready4 - 4'd1)) != 4'b0) errs++;
      for (int b = 0; b < 4; b++) begin
        if (v4[b] && ready4[b]) begin
          sb[b].push_back({idx4[b*IW4 +: IW4], 2'(b), dat4[b*DW +: DW]});
          pend[b] = 1'b0;
          pushed++;
        end
      end
      tick();
    end
    v4 = '0;
    yumi4 = 1'b0;
    left = 0;
    for (int b = 0; b < 4; b++) left += sb[b].size();
    chk("rand_errors", errs, 0);
    chk("rand_leftover", left, 0);
    chk("rand_pending", pend, 4'b0);
    chk("rand_vo_idle", vo4, 1'b0);
    chk("rand_push_pop", popped, pushed);
    chk("rand_traffic", (pushed > 500), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
